// File: rtl/alu_pkg.sv
// alu_pkg: op codes, ALU control encodings and sequencer states shared by the ALU front end.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [3:0] ALUOP_AND  = 4'b0000;
  localparam logic [3:0] ALUOP_OR   = 4'b0001;
  localparam logic [3:0] ALUOP_ADD  = 4'b0010;
  localparam logic [3:0] ALUOP_SLT  = 4'b0011;
  localparam logic [3:0] ALUOP_NEGB = 4'b0110;
  localparam logic [3:0] ALUOP_NOR  = 4'b1100;
  typedef enum logic [1:0] {IDLE, NEG, EXEC, RESP} state_t;
  // SUB reuses ADD because its right operand has already been negated
  function automatic logic [3:0] op_to_aluop(input logic [2:0] op);
    return (op == OP_ADD || op == OP_SUB) ? ALUOP_ADD :
           (op == OP_AND) ? ALUOP_AND :
           (op == OP_OR)  ? ALUOP_OR  :
           (op == OP_NOR) ? ALUOP_NOR :
           (op == OP_SLT) ? ALUOP_SLT : 4'b0000;
  endfunction
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end driving a carry-less ALU, with a negation pass for SUB/SLT.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [2:0]       reqOp,
  input  logic [WIDTH-1:0] reqA,
  input  logic [WIDTH-1:0] reqB,
  output logic [3:0]       aluOp,
  output logic [WIDTH-1:0] aluLeft,
  output logic [WIDTH-1:0] aluRight,
  input  logic [WIDTH-1:0] aluResult,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspResult,
  output logic             rspError
);
  state_t state, state_d;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic accept, two_pass, illegal;
  assign reqReady = state == IDLE;
  assign rspValid = state == RESP;
  assign accept   = reqValid && reqReady;
  assign two_pass = reqOp == OP_SUB || reqOp == OP_SLT;
  assign illegal  = reqOp > OP_SLT;
  // ALU inputs are held at zero outside NEG/EXEC so its outputs stay quiet
  always_comb begin
    aluOp    = state == NEG ? ALUOP_NEGB : state == EXEC ? op_to_aluop(op_q) : 4'b0000;
    aluLeft  = state == NEG ? WIDTH'(1) : state == EXEC ? a_q : '0;
    aluRight = (state == NEG || state == EXEC) ? b_q : '0;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = !reqValid ? IDLE : illegal ? RESP : two_pass ? NEG : EXEC;
      NEG:  state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: state_d = rspReady ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rspResult <= '0;
      rspError  <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q <= reqOp;
        a_q  <= reqA;
        b_q  <= reqB;
        if (illegal) begin
          rspResult <= '0;
          rspError  <= 1'b1;
        end
      end
      if (state == NEG) b_q <= aluResult;
      if (state == EXEC) begin
        rspResult <= aluResult;
        rspError  <= 1'b0;
      end
    end
  end
endmodule
